// File: rtl/branch_checkpoint_manager.sv
// Speculative branch-history checkpoint pool. Slots are allocated in program
// order at decode, resolved out of order at execute and restored on a mispredict.
module branch_checkpoint_manager #(
    parameter int unsigned NUM_CKPT = 8,
    parameter int unsigned STATE_W  = 64,
    parameter int unsigned ID_W     = $clog2(NUM_CKPT)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               alloc_req,
    input  logic [STATE_W-1:0] alloc_state,
    output logic               alloc_gnt,
    output logic [ID_W-1:0]    alloc_id,
    output logic               alloc_color,
    output logic               full,
    output logic               empty,
    input  logic               resolve_valid,
    input  logic [ID_W-1:0]    resolve_id,
    input  logic               resolve_color,
    input  logic               resolve_mispredict,
    input  logic               flush_all,
    output logic               restore_valid,
    output logic [STATE_W-1:0] restore_state,
    output logic [ID_W:0]      occupancy
);
    localparam int unsigned PTR_W = ID_W + 1;

    typedef enum logic {IDLE = 1'b0, RESTORE = 1'b1} fsm_t;

    fsm_t                state, state_next;
    logic [PTR_W-1:0]    head_ptr, tail_ptr, head_next, tail_next;
    logic [PTR_W-1:0]    resolve_ptr, resolve_dist;
    logic [ID_W-1:0]     head_idx, tail_idx;
    logic [NUM_CKPT-1:0] slot_valid, slot_done, slot_color;
    logic [NUM_CKPT-1:0] valid_next, done_next, squash;
    logic [STATE_W-1:0]  slot_state [NUM_CKPT];
    logic [ID_W-1:0]     rel [NUM_CKPT];
    logic                hit, mispredict_hit, retire;

    assign head_idx    = head_ptr[ID_W-1:0];
    assign tail_idx    = tail_ptr[ID_W-1:0];
    assign resolve_ptr = {resolve_color, resolve_id};

    assign full        = (head_idx == tail_idx) && (head_ptr[ID_W] != tail_ptr[ID_W]);
    assign empty       = (head_ptr == tail_ptr);
    assign occupancy   = tail_ptr - head_ptr;
    assign alloc_id    = tail_idx;
    assign alloc_color = tail_ptr[ID_W];

    // A resolve whose slot is dead or recoloured belongs to a squashed branch.
    assign hit = resolve_valid & ~flush_all & slot_valid[resolve_id]
               & (slot_color[resolve_id] == resolve_color);
    assign mispredict_hit = hit & resolve_mispredict;
    assign retire         = slot_valid[head_idx] & slot_done[head_idx];

    assign alloc_gnt = alloc_req & ~full & (state == IDLE) & ~mispredict_hit & ~flush_all;

    // Slots strictly younger than the resolved branch, up to the current tail.
    always_comb begin
        resolve_dist = tail_ptr - resolve_ptr;
        for (int unsigned i = 0; i < NUM_CKPT; i++) begin
            rel[i]    = ID_W'(i) - resolve_id;
            squash[i] = (rel[i] != '0) && ({1'b0, rel[i]} < resolve_dist);
        end
    end

    always_comb begin
        valid_next = slot_valid;
        done_next  = slot_done;
        head_next  = head_ptr;
        tail_next  = tail_ptr;
        if (flush_all) begin
            valid_next = '0;
            head_next  = tail_ptr;
        end else begin
            if (retire) begin
                valid_next[head_idx] = 1'b0;
                head_next            = head_ptr + PTR_W'(1);
            end
            if (alloc_gnt) begin
                valid_next[tail_idx] = 1'b1;
                done_next[tail_idx]  = 1'b0;
                tail_next            = tail_ptr + PTR_W'(1);
            end
            // A mispredicted branch is itself finished; it retires normally.
            if (hit) begin
                done_next[resolve_id] = 1'b1;
            end
            if (mispredict_hit) begin
                valid_next = valid_next & ~squash;
                tail_next  = resolve_ptr + PTR_W'(1);
            end
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (mispredict_hit) state_next = RESTORE;
            RESTORE: state_next = mispredict_hit ? RESTORE : IDLE;
        endcase
        if (flush_all) begin
            state_next = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            head_ptr      <= '0;
            tail_ptr      <= '0;
            slot_valid    <= '0;
            slot_done     <= '0;
            restore_valid <= 1'b0;
            restore_state <= '0;
        end else begin
            head_ptr      <= head_next;
            tail_ptr      <= tail_next;
            slot_valid    <= valid_next;
            slot_done     <= done_next;
            restore_valid <= (state_next == RESTORE);
            if (mispredict_hit) begin
                restore_state <= slot_state[resolve_id];
            end
        end
    end

    // Snapshot payload needs no reset; it is only read behind a valid bit.
    always_ff @(posedge clk) begin
        if (rst_n && alloc_gnt) begin
            slot_state[tail_idx] <= alloc_state;
            slot_color[tail_idx] <= tail_ptr[ID_W];
        end
    end

endmodule

// File: tb/tb_branch_checkpoint_manager.sv
// Bench for branch_checkpoint_manager: directed scenarios plus random traffic,
// all checked against a queue-based model of the live checkpoints.
module tb_branch_checkpoint_manager;
    localparam int N  = 8;
    localparam int SW = 64;
    localparam int IW = 3;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          alloc_req;
    logic [SW-1:0] alloc_state;
    logic          alloc_gnt;
    logic [IW-1:0] alloc_id;
    logic          alloc_color;
    logic          full;
    logic          empty;
    logic          resolve_valid;
    logic [IW-1:0] resolve_id;
    logic          resolve_color;
    logic          resolve_mispredict;
    logic          flush_all;
    logic          restore_valid;
    logic [SW-1:0] restore_state;
    logic [IW:0]   occupancy;

    branch_checkpoint_manager #(.NUM_CKPT(N), .STATE_W(SW)) dut (
        .clk(clk), .rst_n(rst_n),
        .alloc_req(alloc_req), .alloc_state(alloc_state), .alloc_gnt(alloc_gnt),
        .alloc_id(alloc_id), .alloc_color(alloc_color), .full(full), .empty(empty),
        .resolve_valid(resolve_valid), .resolve_id(resolve_id),
        .resolve_color(resolve_color), .resolve_mispredict(resolve_mispredict),
        .flush_all(flush_all), .restore_valid(restore_valid),
        .restore_state(restore_state), .occupancy(occupancy)
    );

    always #5 clk = ~clk;

    // Model: live checkpoints in program order, each tagged with its full pointer.
    typedef struct {
        int            ptr;
        logic [SW-1:0] st;
        bit            done;
    } ent_t;

    ent_t          q[$];
    ent_t          e;
    int            m_tail;
    bit            m_restoring;
    logic [SW-1:0] m_rstate;
    int            checks;
    int            failures;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic drive(input bit req, input logic [SW-1:0] st, input bit rv,
                         input int rid, input bit rc, input bit rm, input bit fl);
        alloc_req          = req;
        alloc_state        = st;
        resolve_valid      = rv;
        resolve_id         = IW'(rid);
        resolve_color      = rc;
        resolve_mispredict = rm;
        flush_all          = fl;
    endtask

    // Check every output against the model, then advance model and DUT one clock.
    task automatic tick();
        int k;
        int rptr;
        bit mhit;
        bit chit;
        bit exp_gnt;
        bit retire_m;
        #1;
        k    = -1;
        rptr = int'(resolve_color) * N + int'(resolve_id);
        if (resolve_valid && !flush_all) begin
            foreach (q[j]) if (q[j].ptr == rptr) k = j;
        end
        mhit    = (k >= 0) && resolve_mispredict;
        chit    = (k >= 0) && !resolve_mispredict;
        exp_gnt = alloc_req && (q.size() < N) && !m_restoring && !mhit && !flush_all;
        if (rst_n) begin
            check("alloc_gnt",     64'(alloc_gnt),     64'(exp_gnt));
            check("alloc_id",      64'(alloc_id),      64'(m_tail % N));
            check("alloc_color",   64'(alloc_color),   64'((m_tail / N) % 2));
            check("full",          64'(full),          64'(q.size() == N));
            check("empty",         64'(empty),         64'(q.size() == 0));
            check("occupancy",     64'(occupancy),     64'(q.size()));
            check("restore_valid", 64'(restore_valid), 64'(m_restoring));
            check("restore_state", restore_state,      m_rstate);
        end
        retire_m = (q.size() > 0) && q[0].done;
        if (!rst_n) begin
            q.delete();
            m_tail      = 0;
            m_restoring = 1'b0;
            m_rstate    = '0;
        end else if (flush_all) begin
            q.delete();
            m_restoring = 1'b0;
        end else begin
            if (mhit) begin
                m_rstate   = q[k].st;
                q[k].done  = 1'b1;
                while (q.size() > k + 1) void'(q.pop_back());
                m_tail     = (q[k].ptr + 1) % (2 * N);
            end else if (chit) begin
                q[k].done = 1'b1;
            end
            if (exp_gnt) begin
                q.push_back('{ptr: m_tail, st: alloc_state, done: 1'b0});
                m_tail = (m_tail + 1) % (2 * N);
            end
            if (retire_m) void'(q.pop_front());
            m_restoring = mhit;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle();
        drive(0, '0, 0, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        idle();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic fill(input int n, input logic [SW-1:0] base);
        for (int i = 0; i < n; i++) begin
            drive(1, base + SW'(i), 0, 0, 0, 0, 0);
            tick();
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        idle();
        @(negedge clk);

        // Reset values, then fill all slots and overflow by one.
        do_reset();
        #1;
        check("rst_restore_valid", 64'(restore_valid), 64'd0);
        check("rst_restore_state", restore_state, 64'd0);
        check("rst_empty", 64'(empty), 64'd1);
        check("rst_full", 64'(full), 64'd0);
        check("rst_occupancy", 64'(occupancy), 64'd0);
        for (int i = 0; i < N; i++) begin
            drive(1, SW'(i), 0, 0, 0, 0, 0);
            #1;
            check("fill_id", 64'(alloc_id), 64'(i));
            check("fill_color", 64'(alloc_color), 64'd0);
            tick();
        end
        drive(1, 64'h99, 0, 0, 0, 0, 0);
        #1;
        check("full_gnt", 64'(alloc_gnt), 64'd0);
        check("full_flag", 64'(full), 64'd1);
        check("full_occ", 64'(occupancy), 64'd8);
        tick();

        // Out-of-order correct resolves retire in order.
        do_reset();
        fill(4, 64'h10);
        drive(0, '0, 1, 2, 0, 0, 0); tick();
        drive(0, '0, 1, 1, 0, 0, 0); tick();
        drive(0, '0, 1, 0, 0, 0, 0); tick();
        idle();
        for (int i = 0; i < 4; i++) tick();
        #1;
        check("ooo_occ", 64'(occupancy), 64'd1);

        // Mispredict restores the snapshot and rewinds the tail.
        do_reset();
        fill(6, 64'hA0);
        drive(0, '0, 1, 2, 0, 1, 0); tick();
        drive(1, 64'h55, 0, 0, 0, 0, 0);
        #1;
        check("mp_restore_valid", 64'(restore_valid), 64'd1);
        check("mp_restore_state", restore_state, 64'hA2);
        tick();
        drive(1, 64'h56, 0, 0, 0, 0, 0);
        #1;
        check("mp_next_gnt", 64'(alloc_gnt), 64'd1);
        check("mp_next_id", 64'(alloc_id), 64'd3);
        check("mp_next_color", 64'(alloc_color), 64'd0);
        tick();

        // Wrap to color 1; a stale color-0 resolve is ignored.
        do_reset();
        fill(8, 64'h200);
        for (int i = 0; i < N; i++) begin
            drive(0, '0, 1, i, 0, 0, 0);
            tick();
        end
        idle();
        for (int i = 0; i < 3; i++) tick();
        drive(1, 64'h300, 0, 0, 0, 0, 0);
        #1;
        check("wrap_id", 64'(alloc_id), 64'd0);
        check("wrap_color", 64'(alloc_color), 64'd1);
        tick();
        drive(0, '0, 1, 0, 0, 1, 0); tick();
        idle();
        #1;
        check("stale_occ", 64'(occupancy), 64'd1);
        check("stale_restore", 64'(restore_valid), 64'd0);
        tick();

        // Allocation colliding with a head mispredict.
        do_reset();
        fill(1, 64'h400);
        drive(1, 64'h401, 1, 0, 0, 1, 0);
        #1;
        check("coll_gnt", 64'(alloc_gnt), 64'd0);
        tick();
        drive(1, 64'h402, 0, 0, 0, 0, 0);
        #1;
        check("coll_restore_gnt", 64'(alloc_gnt), 64'd0);
        tick();
        #1;
        check("coll_resume_gnt", 64'(alloc_gnt), 64'd1);
        check("coll_resume_id", 64'(alloc_id), 64'd1);
        tick();

        // Flush overrides a simultaneous mispredict.
        do_reset();
        fill(3, 64'h500);
        drive(1, 64'h5FF, 1, 1, 0, 1, 1); tick();
        idle();
        #1;
        check("flush_empty", 64'(empty), 64'd1);
        check("flush_restore", 64'(restore_valid), 64'd0);
        drive(1, 64'h510, 0, 0, 0, 0, 0);
        #1;
        check("flush_next_id", 64'(alloc_id), 64'd3);
        tick();

        // Random traffic, including occasional reset and flush.
        do_reset();
        for (int c = 0; c < 4000; c++) begin
            bit rv;
            bit rc;
            int rid;
            rv  = ($urandom_range(0, 9) < 4);
            rid = int'($urandom_range(0, N - 1));
            rc  = 1'($urandom_range(0, 1));
            if (rv && q.size() > 0 && $urandom_range(0, 3) != 0) begin
                e   = q[$urandom_range(0, q.size() - 1)];
                rid = e.ptr % N;
                rc  = 1'((e.ptr / N) % 2);
            end
            drive(($urandom_range(0, 9) < 6), {$urandom, $urandom}, rv, rid, rc,
                  ($urandom_range(0, 4) == 0), ($urandom_range(0, 49) == 0));
            rst_n = ($urandom_range(0, 99) != 0);
            tick();
        end
        rst_n = 1'b1;
        idle();
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
